// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, round counts and sequencer types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_NR_128 = 10;
    localparam int AES_NR_256 = 14;

    // Sequencer phases: waiting for plaintext, iterating rounds, holding ciphertext
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_ctrl_state_t;

    // Round index / round key index (0..14 fits in 4 bits)
    typedef logic [3:0] aes_rnd_idx_t;

    // Round count for a block given its key size
    function automatic aes_rnd_idx_t aes_nr_sel(input logic key256);
        return key256 ? aes_rnd_idx_t'(AES_NR_256) : aes_rnd_idx_t'(AES_NR_128);
    endfunction

endpackage

// File: rtl/aes_enc_round_ctrl.sv
// aes_enc_round_ctrl: iterative AES encrypt sequencer; owns state register, round counter and AddRoundKey.
// Latency: Nr cycles from accept to out_valid (Nr=10, or 14 with key256); one block every Nr+2 cycles.
// Backpressure: ciphertext held in DONE until out_ready; in_ready low outside IDLE, in_valid there is dropped.
// Build option: AES_CTRL_KEY256_EN adds the key256 port and the 14-round mode.
module aes_enc_round_ctrl
    import aes_pkg::*;
#(
    parameter int BLK_W = AES_BLK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic [3:0]       rk_idx,
    input  logic [BLK_W-1:0] rk,
    output logic [BLK_W-1:0] rnd_state,
    output logic             rnd_last,
    input  logic [BLK_W-1:0] rnd_result,
    output logic             busy
`ifdef AES_CTRL_KEY256_EN
    ,
    input  logic             key256
`endif
);

    aes_ctrl_state_t  fsm;
    logic [BLK_W-1:0] state_q;
    aes_rnd_idx_t     cnt;
    aes_rnd_idx_t     nr;
    logic             last_rnd;
    logic [BLK_W-1:0] key_src;
    logic [BLK_W-1:0] state_nxt;

    // The same XOR serves the initial AddRoundKey (plaintext in IDLE) and
    // the per-round AddRoundKey (round unit output in ROUND). rk follows
    // rk_idx combinationally, so this is the single-cycle critical path.
    assign key_src   = (fsm == IDLE) ? in_data : rnd_result;
    assign state_nxt = key_src ^ rk;
    assign last_rnd  = (cnt == nr);

    assign rnd_state = state_q;
    assign out_data  = state_q;

`ifdef AES_CTRL_KEY256_EN
    aes_rnd_idx_t nr_q;

    // Round count is captured with the plaintext so key256 changes mid-block do not matter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nr_q <= aes_rnd_idx_t'(AES_NR_128);
        end else if (fsm == IDLE && in_valid) begin
            nr_q <= aes_nr_sel(key256);
        end
    end

    assign nr = nr_q;
`else
    assign nr = aes_rnd_idx_t'(AES_NR_128);
`endif

    // Sequencer FSM: state register, round counter and all registered handshake/round outputs.
    // rk_idx and rnd_last are computed one cycle ahead so they are plain flops at the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            state_q   <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            rnd_last  <= 1'b0;
            rk_idx    <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_q  <= state_nxt;
                        cnt      <= aes_rnd_idx_t'(1);
                        rk_idx   <= 4'd1;
                        rnd_last <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        fsm      <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= state_nxt;
                    if (last_rnd) begin
                        // cnt parks at Nr; rk_idx returns to 0 for the output phase
                        rk_idx    <= '0;
                        rnd_last  <= 1'b0;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        cnt      <= cnt + 4'd1;
                        rk_idx   <= cnt + 4'd1;
                        rnd_last <= ((cnt + 4'd1) == nr);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end
                default: begin
                    cnt       <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    rnd_last  <= 1'b0;
                    rk_idx    <= '0;
                    fsm       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// tb_aes_enc_round_ctrl: directed FIPS-197 vectors through the sequencer with a behavioural round unit.
// Latency: n/a (bench).
// Backpressure: exercises out_ready stalls, back-to-back streaming and mid-block reset.
module tb_aes_enc_round_ctrl;

    typedef struct {
        logic [127:0] pt;
        logic [255:0] key;
        logic         is256;
        logic [127:0] ct;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, rnd_last, busy;
    logic [127:0] in_data, out_data, rk, rnd_state, rnd_result;
    logic [3:0]   rk_idx;
`ifdef AES_CTRL_KEY256_EN
    logic         key256;
`endif

    logic [127:0] rkeys [16];
    logic [7:0]   sbox_t [256];

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];

    aes_enc_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .rnd_state  (rnd_state),
        .rnd_last   (rnd_last),
        .rnd_result (rnd_result),
        .busy       (busy)
`ifdef AES_CTRL_KEY256_EN
        ,
        .key256     (key256)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- behavioural AES pieces ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xt(x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] r, base, inv;
        int e;
        r = 8'h01;
        base = x;
        e = 254;
        while (e != 0) begin
            if (e % 2 == 1) r = gmul(r, base);
            base = gmul(base, base);
            e = e / 2;
        end
        inv = r;
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                t[w + 4*c] = b[w + 4*((c + w) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Key schedule into the round-key store; 128-bit keys sit in key[255:128]
    task automatic expand(input logic [255:0] key, input logic is256);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        int nk, nrk, tot;
        nk   = is256 ? 8 : 4;
        nrk  = is256 ? 14 : 10;
        tot  = 4 * (nrk + 1);
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < tot; i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp  = subw({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r < 16; r++)
            rkeys[r] = (r <= nrk) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // Round unit and key store as the parent would wire them
    always_comb rnd_result = aes_round(rnd_state, rnd_last);
    always_comb rk = rkeys[rk_idx];

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts just after a negedge in IDLE; returns at the negedge where out_valid is first seen
    task automatic run_block(input vec_t v, input bit trace);
        int nr;
        int n;
        nr = v.is256 ? 14 : 10;
        expand(v.key, v.is256);
        check("idle_in_ready", in_ready, 1);
        check("idle_rk_idx", rk_idx, 0);
        in_data  = v.pt;
        in_valid = 1'b1;
`ifdef AES_CTRL_KEY256_EN
        key256 = v.is256;
`endif
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~v.pt;
`ifdef AES_CTRL_KEY256_EN
        key256 = ~v.is256;
`endif
        n = 0;
        while (!out_valid && n < 40) begin
            if (trace) begin
                check("trace_rk_idx", rk_idx, n + 1);
                check("trace_rnd_last", rnd_last, (n + 1 == nr));
                check("trace_busy", busy, 1);
                check("trace_in_ready", in_ready, 0);
            end
            @(negedge clk);
            n++;
        end
        check("latency", n, nr);
        check("ciphertext", out_data, v.ct);
        if (trace) begin
            check("done_rk_idx", rk_idx, 0);
            check("done_rnd_last", rnd_last, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] held;
        int acc_t [2];
        int acc_cnt;
        int got;
        int cyc;

        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        for (int r = 0; r < 16; r++) rkeys[r] = '0;

        vecs.push_back('{128'h00112233445566778899aabbccddeeff,
                         {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0,
                         128'h69c4e0d86a7b0430d8cdb78070b4c55a});
        vecs.push_back('{128'h3243f6a8885a308d313198a2e0370734,
                         {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0,
                         128'h3925841d02dc09fbdc118597196a0b32});
`ifdef AES_CTRL_KEY256_EN
        vecs.push_back('{128'h00112233445566778899aabbccddeeff,
                         256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1,
                         128'h8ea2b7ca516745bfeafc49904b496089});
        key256 = 1'b0;
`endif

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rnd_last", rnd_last, 0);
        check("rst_rk_idx", rk_idx, 0);
        check("rst_state", rnd_state, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table: every vector, trace checks on the first
        for (int i = 0; i < vecs.size(); i++) begin
            run_block(vecs[i], i == 0);
            @(negedge clk);
            check("post_done_out_valid", out_valid, 0);
            check("post_done_in_ready", in_ready, 1);
        end

        // Backpressure: hold DONE for 5 cycles with in_valid pulses that must be dropped
        out_ready = 1'b0;
        run_block(vecs[0], 1'b0);
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = 128'hdeadbeef_00000000_12345678_00000000 + 128'(k);
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, held);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        @(negedge clk);
        check("bp_no_queued_block", busy, 0);

        // Back-to-back with in_valid and out_ready tied high
        expand(vecs[0].key, 1'b0);
        in_data = vecs[0].pt; in_valid = 1'b1; out_ready = 1'b1;
        acc_cnt = 0; got = 0; cyc = 0;
        while (got < 2 && cyc < 60) begin
            if (in_ready && in_valid && acc_cnt < 2) begin
                acc_t[acc_cnt] = cyc;
                acc_cnt++;
            end
            if (out_valid) begin
                check("b2b_ciphertext", out_data, vecs[got].ct);
                got++;
                if (got == 1) begin
                    expand(vecs[1].key, 1'b0);
                    in_data = vecs[1].pt;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b_blocks_out", got, 2);
        check("b2b_accept_count", acc_cnt, 2);
        check("b2b_accept_spacing", (acc_cnt == 2) ? acc_t[1] - acc_t[0] : -1, 12);
        @(negedge clk);

        // Reset at round 5 aborts the block; a fresh block afterwards is correct
        expand(vecs[0].key, 1'b0);
        in_data = vecs[0].pt; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (rk_idx != 4'd5 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_rst_reached_round5", rk_idx, 5);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rnd_last", rnd_last, 0);
        check("mid_rst_rk_idx", rk_idx, 0);
        check("mid_rst_state", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_block(vecs[1], 1'b0);
        @(negedge clk);
        check("after_rst_idle", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_enc_round_ctrl.md
# aes_enc_round_ctrl

Iterative AES encryption sequencer. It owns the 128-bit cipher state register and the round counter, and performs the initial and per-round AddRoundKey. It drives one external combinational round unit (SubBytes, ShiftRows, then MixColumns except in the final round) once per cycle. It sits between the block-level valid/ready stream and the round-key store, and the parent instantiates the round unit next to it.

## Interface
Parameters:
- BLK_W, 128, block and state width; fixed at 128, present for package consistency.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  block can accept plaintext.
- in_data  in  128  plaintext; byte 0 in [127:120], column-major.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  downstream accepts ciphertext.
- out_data  out  128  ciphertext, same byte order as in_data.
- rk_idx  out  4  round-key index requested this cycle.
- rk  in  128  round key for rk_idx, combinational, same cycle.
- rnd_state  out  128  state presented to the round unit; equals the state register.
- rnd_last  out  1  final round; the round unit must bypass MixColumns.
- rnd_result  in  128  round unit output, without key addition.
- busy  out  1  high in ROUND and DONE.
- key256  in  1  selects 14 rounds. Present only with AES_CTRL_KEY256_EN.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, rk_idx=0.
  - On in_valid: state <= in_data ^ rk, cnt <= 1, Nr latched (10, or 14 if key256), go to ROUND.
- ROUND:
  - rk_idx=cnt, rnd_last=(cnt==Nr).
  - Each cycle: state <= rnd_result ^ rk, cnt <= cnt+1.
  - When cnt==Nr, go to DONE instead of incrementing.
- DONE:
  - out_valid=1, out_data=state.
  - Held stable until out_ready, then go to IDLE.
  - out_ready may already be high on DONE entry.
- in_ready is 0 outside IDLE. in_valid there is ignored, not queued.
- Nr is latched at accept. Changing key256 mid-block has no effect on that block.
- Outputs outside their state:
  - rnd_last=0 outside ROUND.
  - out_data reflects the state register at all times; it is valid only with out_valid.
- cnt is 4 bits, never exceeds Nr, and never wraps.
- rk_idx is don't-care-free: 0 in IDLE and DONE.
- Reset mid-block aborts the block. No partial output is produced.

## Timing
- Reset values:
  - Outputs: in_ready=1, out_valid=0, busy=0, rnd_last=0, rk_idx=0.
  - Registers: state=0, cnt=0, FSM=IDLE.
- Accept at edge E. ROUND is active for cycles E+1..E+Nr. out_valid rises after edge E+Nr.
  - Latency: Nr cycles (10 or 14).
- With out_ready held high, DONE lasts one cycle. The next accept occurs at edge E+Nr+2.
  - Throughput: one block per Nr+2 cycles.
- The rk/rk_idx path and the rnd_state→rnd_result path are combinational into the state register. Both form the single-cycle critical path.

## Configuration
- AES_CTRL_KEY256_EN defined:
  - key256 port exists.
  - Nr is 10 or 14 per key256 at accept.
  - rk_idx reaches 14.
- Undefined:
  - No key256 port.
  - Nr is the constant 10.
  - rk_idx never exceeds 10.

## Structure
- Shared package aes_pkg holds:
  - AES_BLK_W=128, AES_NR_128=10, AES_NR_256=14.
  - The FSM state enum aes_ctrl_state_t (IDLE/ROUND/DONE).
  - The 4-bit round-index typedef aes_rnd_idx_t.
- No sub-module. FSM, counter and key XOR are inline.
- The round unit, which builds on the existing MixColumns, is instantiated by the parent, not inside this block.

## Test plan
- FIPS-197 C.1, AES-128:
  - Stimulus: pt 00112233445566778899aabbccddeeff, keys expanded from 000102…0f, behavioural round unit.
  - Response: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
- rk_idx/rnd_last trace:
  - rk_idx is 0 at accept, then 1..10 in ROUND.
  - rnd_last is high only in the cycle with rk_idx=10.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid: out_data is stable, in_ready=0, and in_valid pulses are ignored.
  - Release: IDLE on the next cycle.
- Back-to-back with in_valid and out_ready tied high: accepts are 12 cycles apart, and two distinct vectors both match.
- Reset mid-operation: assert rst at ROUND cnt=5 → all outputs at reset values. A fresh block afterwards produces the correct ciphertext.
- With AES_CTRL_KEY256_EN, key256=1:
  - Stimulus: FIPS-197 C.3, key 000102…1f.
  - Response: out_data=8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
